// File: rtl/game_ctrl_if.sv
// Control/status bundle between the falling-block game controller and its board.
// Latency: none (wires only). Backpressure: none; pulses are single-cycle and not held.
interface game_ctrl_if;
    logic       start;
    logic       pause;
    logic       btn_left;
    logic       btn_right;
    logic       btn_rot;
    logic       btn_down;
    logic       el;
    logic       er;
    logic       eu;
    logic       edrop;
    logic       overflow;
    logic       refresh_done;
    logic [4:0] x;
    logic [4:0] y;
    logic [2:0] piece_type;
    logic [1:0] dir;
    logic [2:0] next_type;
    logic       refresh;
    logic       game_over;
    logic [15:0] piece_cnt;
    logic [2:0] state;

    modport master (
        output start, pause, btn_left, btn_right, btn_rot, btn_down,
        output el, er, eu, edrop, overflow, refresh_done,
        input  x, y, piece_type, dir, next_type, refresh, game_over, piece_cnt, state
    );

    modport slave (
        input  start, pause, btn_left, btn_right, btn_rot, btn_down,
        input  el, er, eu, edrop, overflow, refresh_done,
        output x, y, piece_type, dir, next_type, refresh, game_over, piece_cnt, state
    );
endinterface

// File: rtl/game_ctrl.sv
// Falling-block game FSM: spawn, gravity, player moves, pause, lock/clear handshake.
// Latency: one cycle from request to updated outputs. Backpressure: none; losing requests are dropped.
module game_ctrl #(
    parameter int DROP_PERIOD = 25000000,
    parameter int SPAWN_X     = 3
) (
    input  logic        clk,
    input  logic        rstn,
    game_ctrl_if.slave  gc
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SPAWN = 3'd1,
        CHECK = 3'd2,
        FALL  = 3'd3,
        PAUSE = 3'd4,
        LOCK  = 3'd5,
        CLEAR = 3'd6,
        OVER  = 3'd7
    } state_e;

    localparam int CW = $clog2(DROP_PERIOD);
    localparam logic [CW-1:0] GRAV_LAST = CW'(DROP_PERIOD - 1);
    localparam logic [4:0]    X_SPAWN   = 5'(SPAWN_X);

    state_e        state_q, state_d;
    logic [4:0]    x_q, x_d, y_q, y_d;
    logic [2:0]    type_q, type_d, next_q, next_d;
    logic [1:0]    dir_q, dir_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [CW-1:0] grav_q, grav_d;
    logic [7:0]    lfsr_q, lfsr_d;
    logic          refresh_q, game_over_q;
    logic          tick;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        type_d  = type_q;
        dir_d   = dir_q;
        next_d  = next_q;
        cnt_d   = cnt_q;
        grav_d  = grav_q;
        lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        tick    = (grav_q == GRAV_LAST);

        case (state_q)
            IDLE: if (gc.start) state_d = SPAWN;
            SPAWN: begin
                x_d     = X_SPAWN;
                y_d     = '0;
                dir_d   = '0;
                type_d  = next_q;
                next_d  = (lfsr_q[2:0] == 3'd7) ? 3'd0 : lfsr_q[2:0];
                state_d = CHECK;
            end
            CHECK: begin
                if (gc.overflow) begin
                    state_d = OVER;
                end else begin
                    state_d = FALL;
                    grav_d  = '0;
                end
            end
            FALL: begin
                grav_d = tick ? '0 : grav_q + CW'(1);
                // Single action per cycle; anything that loses arbitration is dropped.
                if (tick || gc.btn_down) begin
                    if (gc.edrop) begin
                        y_d    = y_q + 5'd1;
                        grav_d = '0;
                    end else begin
                        state_d = LOCK;
                    end
                end else if (gc.btn_rot) begin
                    if (gc.eu) dir_d = dir_q + 2'd1;
                end else if (gc.btn_left) begin
                    if (gc.el) x_d = x_q - 5'd1;
                end else if (gc.btn_right) begin
                    if (gc.er) x_d = x_q + 5'd1;
                end else if (gc.pause) begin
                    state_d = PAUSE;
                end
            end
            PAUSE: if (gc.pause) state_d = FALL;
            LOCK: begin
                cnt_d   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
                state_d = CLEAR;
            end
            CLEAR: if (gc.refresh_done) state_d = SPAWN;
            OVER: begin
                if (gc.start) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            x_q         <= X_SPAWN;
            y_q         <= '0;
            type_q      <= '0;
            dir_q       <= '0;
            next_q      <= '0;
            cnt_q       <= '0;
            grav_q      <= '0;
            lfsr_q      <= 8'h01;
            refresh_q   <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            type_q      <= type_d;
            dir_q       <= dir_d;
            next_q      <= next_d;
            cnt_q       <= cnt_d;
            grav_q      <= grav_d;
            lfsr_q      <= lfsr_d;
            // Registered so the level/pulse lines up exactly with the state they belong to.
            refresh_q   <= (state_d == LOCK);
            game_over_q <= (state_d == OVER);
        end
    end

    assign gc.x          = x_q;
    assign gc.y          = y_q;
    assign gc.piece_type = type_q;
    assign gc.dir        = dir_q;
    assign gc.next_type  = next_q;
    assign gc.refresh    = refresh_q;
    assign gc.game_over  = game_over_q;
    assign gc.piece_cnt  = cnt_q;
    assign gc.state      = state_q;
endmodule
